ddr3_cmd_queue: RTL and testbench
=================================

# ddr3_cmd_queue

CPU-side front end of the DDR3 memory controller. Accepts READ/WRITE requests from the CPU traffic generator over the address/command/write-data handshake and collects full write bursts. Queues commands and write data in order and presents them to the controller core's scheduler through a valid/ready command port and a first-word-fall-through write-data port. A write command is never visible downstream before its complete burst is buffered.

## Interface
- DEPTH, 4: command FIFO entries; power of two, ≥2
- BURST_LEN, 8: 64-bit write beats per WRITE command; power of two
- cpu_clk  in  1  single clock for the block
- cpu_rst  in  1  asynchronous, active-high reset
- cpu_addr_valid  in  1  CPU request valid
- cpu_cmd  in  3  3'b001 READ, 3'b010 WRITE, others invalid
- cpu_ba  in  3  bank address
- cpu_addr  in  15  row/column address
- cpu_wr_data  in  64  write beat
- cpu_cmd_rdy  out  1  block can accept a request this cycle
- cpu_wr_data_valid  out  1  cpu_wr_data is sampled at this edge
- mc_cmd_valid  out  1  head command valid
- mc_cmd_ready  in  1  core takes head command
- mc_cmd / mc_ba / mc_addr  out  3 / 3 / 15  head command fields
- mc_wr_data  out  64  head of write-data FIFO (FWFT)
- mc_wr_data_empty  out  1  write-data FIFO empty
- mc_wr_data_pop  in  1  core consumes mc_wr_data
- cmd_err  out  1  sticky: invalid cpu_cmd was accepted
- stat_wr_cnt / stat_rd_cnt  out  16 / 16  accepted-command counters (see Configuration)

## Operation
- Capture FSM states: IDLE, WDATA. Reset → IDLE.
- cpu_cmd_rdy = !cpu_rst & state==IDLE & cmd FIFO not full & free data slots ≥ BURST_LEN.
- Accept = cpu_addr_valid & cpu_cmd_rdy at a cpu_clk edge.
- READ accepted: {cmd,ba,addr} is pushed at that edge; state stays IDLE.
- WRITE accepted: fields are latched; state → WDATA; beat counter is cleared.
- WDATA: cpu_wr_data_valid=1; each edge pushes cpu_wr_data and increments the counter (width $clog2(BURST_LEN)). The edge that takes beat BURST_LEN-1 pushes the latched command and returns to IDLE.
- Invalid cmd accepted: nothing is pushed; cmd_err sets and is cleared only by reset.
- Downstream: mc_cmd_valid = cmd FIFO not empty. Pop on mc_cmd_valid & mc_cmd_ready.
- mc_wr_data_pop while empty is ignored; the pointer does not move.
- FIFO pointers wrap modulo depth. Occupancy counters are $clog2(depth)+1 bits wide. Simultaneous push and pop keeps the count unchanged, including at full and at empty+1.
- Order is preserved: the core pops BURST_LEN data beats per WRITE it takes.

## Timing
- Reset values: cpu_cmd_rdy 0, cpu_wr_data_valid 0, mc_cmd_valid 0, mc_wr_data_empty 1, mc_cmd/ba/addr/wr_data 0, cmd_err 0, stats 0; FIFOs empty.
- cpu_cmd_rdy may be 1 in the first cycle after cpu_rst falls.
- READ accepted at edge T: mc_cmd_valid=1 in cycle T+1.
- WRITE accepted at edge T: cpu_wr_data_valid=1 during cycles T+1..T+BURST_LEN; beats are sampled on those edges; mc_cmd_valid=1 in cycle T+BURST_LEN+1.
- First data beat: mc_wr_data_empty=0 in cycle T+2.
- cpu_cmd_rdy is 0 for the whole of WDATA. Next accept is at edge T+BURST_LEN+1 at the earliest.
- Reset mid-burst: the partial burst and latched command are discarded; no orphan data remains.
- Back-to-back READs: one per cycle while not full.

## Configuration
- DDR3_CMDQ_STATS_EN defined:
  - stat_wr_cnt increments at the push of each WRITE command.
  - stat_rd_cnt increments at the push of each READ.
  - Both saturate at 16'hFFFF.
- Undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- ddr3_mem_pkg additions:
  - cmd encodings CMD_READ=3'b001, CMD_WRITE=3'b010
  - packed struct cmd_entry_t {cmd, ba, addr}
  - enum cmdq_state_t {CQ_IDLE, CQ_WDATA}
- One sub-module, ddr3_sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count; FWFT; async active-high reset). Instantiated twice:
  - command FIFO, DEPTH entries of cmd_entry_t
  - data FIFO, DEPTH*BURST_LEN entries of 64 bits

## Test plan
- Reset, then release → all outputs at reset values; cpu_cmd_rdy=1 in the next cycle.
- READ ba=2 addr=15'h7FFD with mc_cmd_ready=1 → mc_cmd=001, ba=2, addr=7FFD valid exactly one cycle later, then mc_cmd_valid=0.
- WRITE addr=15'h7FFD with beats 0..7 → 8 cycles of cpu_wr_data_valid; mc_cmd_valid at T+9; popping gives data 0..7 in order, then mc_wr_data_empty=1.
- mc_cmd_ready=0 with 4 READs → cpu_cmd_rdy=0 after the 4th. Raise mc_cmd_ready together with a 5th request → the 5th is accepted at the first edge where rdy=1; the count never exceeds 4.
- cpu_rst pulse after beat 3 of a WRITE → mc_cmd_valid stays 0 and mc_wr_data_empty stays 1.
- cpu_cmd=3'b111 accepted → nothing queued; cmd_err=1 until reset; with DDR3_CMDQ_STATS_EN, counters unchanged while 3 WRITEs and 2 READs read back 3/2.

Source files
------------

// File: rtl/ddr3_mem_pkg.sv
// Shared DDR3 controller types: command encodings, queue entry layout and capture FSM states.
package ddr3_mem_pkg;

    localparam int unsigned CMD_W  = 3;
    localparam int unsigned BA_W   = 3;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STAT_W = 16;

    localparam logic [CMD_W-1:0] CMD_READ  = 3'b001;
    localparam logic [CMD_W-1:0] CMD_WRITE = 3'b010;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [BA_W-1:0]   ba;
        logic [ADDR_W-1:0] addr;
    } cmd_entry_t;

    typedef enum logic {
        CQ_IDLE,
        CQ_WDATA
    } cmdq_state_t;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/ddr3_cmd_queue_if.sv
// CPU request / controller-core bundle for ddr3_cmd_queue.
// slave = queue side, master = traffic generator / core side.
interface ddr3_cmd_queue_if;
    import ddr3_mem_pkg::*;

    logic                 cpu_addr_valid;
    logic [CMD_W-1:0]     cpu_cmd;
    logic [BA_W-1:0]      cpu_ba;
    logic [ADDR_W-1:0]    cpu_addr;
    logic [DATA_W-1:0]    cpu_wr_data;
    logic                 cpu_cmd_rdy;
    logic                 cpu_wr_data_valid;

    logic                 mc_cmd_valid;
    logic                 mc_cmd_ready;
    logic [CMD_W-1:0]     mc_cmd;
    logic [BA_W-1:0]      mc_ba;
    logic [ADDR_W-1:0]    mc_addr;
    logic [DATA_W-1:0]    mc_wr_data;
    logic                 mc_wr_data_empty;
    logic                 mc_wr_data_pop;

    logic                 cmd_err;
    logic [STAT_W-1:0]    stat_wr_cnt;
    logic [STAT_W-1:0]    stat_rd_cnt;

    modport slave (
        input  cpu_addr_valid, cpu_cmd, cpu_ba, cpu_addr, cpu_wr_data,
        output cpu_cmd_rdy, cpu_wr_data_valid,
        output mc_cmd_valid, mc_cmd, mc_ba, mc_addr, mc_wr_data, mc_wr_data_empty,
        input  mc_cmd_ready, mc_wr_data_pop,
        output cmd_err, stat_wr_cnt, stat_rd_cnt
    );

    modport master (
        output cpu_addr_valid, cpu_cmd, cpu_ba, cpu_addr, cpu_wr_data,
        input  cpu_cmd_rdy, cpu_wr_data_valid,
        input  mc_cmd_valid, mc_cmd, mc_ba, mc_addr, mc_wr_data, mc_wr_data_empty,
        output mc_cmd_ready, mc_wr_data_pop,
        input  cmd_err, stat_wr_cnt, stat_rd_cnt
    );

endinterface

// File: rtl/ddr3_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. DEPTH must be a power of two (>= 2).
// Pop on empty is ignored; push on full is accepted only together with a pop.
module ddr3_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array, written on accepted push.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ddr3_cmd_queue.sv
// CPU-side command/write-data front end of the DDR3 controller.
// Collects full write bursts before exposing the WRITE command downstream.
// Optional: define DDR3_CMDQ_STATS_EN to build the saturating READ/WRITE counters.
module ddr3_cmd_queue
    import ddr3_mem_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned BURST_LEN = 8
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rst,
    ddr3_cmd_queue_if.slave        bus
);

    localparam int unsigned DDEPTH = DEPTH * BURST_LEN;
    localparam int unsigned CCW    = $clog2(DEPTH) + 1;
    localparam int unsigned DCW    = $clog2(DDEPTH) + 1;
    localparam int unsigned BW     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned CEW    = $bits(cmd_entry_t);

    cmdq_state_t      state_q, state_d;
    logic [BW-1:0]    beat_q, beat_d;
    cmd_entry_t       lat_q;
    logic             latch_en;
    logic             err_set;
    logic             cmd_err_q;

    logic             cmd_push;
    cmd_entry_t       cmd_din;
    cmd_entry_t       cmd_head;
    logic             cmd_full;
    logic             cmd_empty;
    logic [CCW-1:0]   cmd_count;

    logic             data_push;
    logic             data_full;
    logic             data_empty;
    logic [DCW-1:0]   data_count;
    logic [DCW-1:0]   data_free;
    logic             cmd_rdy_c;
    logic             accept_c;

    assign data_free = DCW'(DDEPTH) - data_count;
    assign cmd_rdy_c = ~cpu_rst & (state_q == CQ_IDLE) & ~cmd_full
                     & (data_free >= DCW'(BURST_LEN));
    assign accept_c  = bus.cpu_addr_valid & cmd_rdy_c;

    // Capture FSM state register and beat counter.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q <= CQ_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state and push control for the capture FSM.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        latch_en  = 1'b0;
        err_set   = 1'b0;
        cmd_push  = 1'b0;
        cmd_din   = lat_q;
        data_push = 1'b0;
        case (state_q)
            CQ_IDLE: begin
                if (accept_c) begin
                    case (bus.cpu_cmd)
                        CMD_READ: begin
                            cmd_push = 1'b1;
                            cmd_din  = '{cmd: bus.cpu_cmd, ba: bus.cpu_ba, addr: bus.cpu_addr};
                        end
                        CMD_WRITE: begin
                            latch_en = 1'b1;
                            beat_d   = '0;
                            state_d  = CQ_WDATA;
                        end
                        default: err_set = 1'b1;
                    endcase
                end
            end
            CQ_WDATA: begin
                data_push = 1'b1;
                beat_d    = beat_q + BW'(1);
                if (beat_q == BW'(BURST_LEN - 1)) begin
                    cmd_push = 1'b1;
                    state_d  = CQ_IDLE;
                end
            end
            default: state_d = CQ_IDLE;
        endcase
    end

    // Holds the WRITE command until its burst is fully buffered.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            lat_q <= '0;
        end else if (latch_en) begin
            lat_q <= '{cmd: bus.cpu_cmd, ba: bus.cpu_ba, addr: bus.cpu_addr};
        end
    end

    // Sticky invalid-command flag, cleared only by reset.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            cmd_err_q <= 1'b0;
        end else if (err_set) begin
            cmd_err_q <= 1'b1;
        end
    end

    ddr3_sync_fifo #(.WIDTH(CEW), .DEPTH(DEPTH)) u_cmd_fifo (
        .clk   (cpu_clk),
        .rst   (cpu_rst),
        .push  (cmd_push),
        .pop   (bus.mc_cmd_ready),
        .din   (cmd_din),
        .dout  (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    ddr3_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DDEPTH)) u_data_fifo (
        .clk   (cpu_clk),
        .rst   (cpu_rst),
        .push  (data_push),
        .pop   (bus.mc_wr_data_pop),
        .din   (bus.cpu_wr_data),
        .dout  (bus.mc_wr_data),
        .full  (data_full),
        .empty (data_empty),
        .count (data_count)
    );

    assign bus.cpu_cmd_rdy       = cmd_rdy_c;
    assign bus.cpu_wr_data_valid = (state_q == CQ_WDATA);
    assign bus.mc_cmd_valid      = ~cmd_empty;
    assign bus.mc_cmd            = cmd_head.cmd;
    assign bus.mc_ba             = cmd_head.ba;
    assign bus.mc_addr           = cmd_head.addr;
    assign bus.mc_wr_data_empty  = data_empty;
    assign bus.cmd_err           = cmd_err_q;

`ifdef DDR3_CMDQ_STATS_EN
    logic [STAT_W-1:0] wr_cnt_q;
    logic [STAT_W-1:0] rd_cnt_q;

    // Count commands at the moment they enter the command FIFO.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (cmd_push && (state_q == CQ_WDATA)) wr_cnt_q <= sat_inc(wr_cnt_q);
            if (cmd_push && (state_q == CQ_IDLE))  rd_cnt_q <= sat_inc(rd_cnt_q);
        end
    end

    assign bus.stat_wr_cnt = wr_cnt_q;
    assign bus.stat_rd_cnt = rd_cnt_q;
`else
    assign bus.stat_wr_cnt = '0;
    assign bus.stat_rd_cnt = '0;
`endif

    // The command FIFO never holds more than DEPTH entries.
    a_cmd_bound: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
        cmd_count <= CCW'(DEPTH));

    // Space for a whole burst is reserved at accept, so data never overflows.
    a_no_data_overflow: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
        !(data_full && data_push));

endmodule

// File: tb/tb_ddr3_cmd_queue.sv
// Scoreboard bench for ddr3_cmd_queue: a queue-based reference model predicts
// accepts, queued commands and buffered beats; a negedge monitor compares.
module tb_ddr3_cmd_queue;
    import ddr3_mem_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned BL     = 8;
    localparam int unsigned DDEPTH = DEPTH * BL;

    logic cpu_clk = 1'b0;
    logic cpu_rst = 1'b1;

    always #5 cpu_clk = ~cpu_clk;

    ddr3_cmd_queue_if bus();

    ddr3_cmd_queue #(.DEPTH(DEPTH), .BURST_LEN(BL)) dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    cmd_entry_t  m_cmdq[$];
    logic [63:0] m_dataq[$];
    bit          m_busy;
    int          m_beats;
    cmd_entry_t  m_pend;
    bit          m_err;
    int          m_wr;
    int          m_rd;
    bit          acc_pending;
    bit          exp_rdy;
    cmd_entry_t  exp_e;
    logic [63:0] exp_d;
    bit          ok;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat16(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Monitor + model: compare at negedge, then advance the model across the next edge.
    always @(negedge cpu_clk) begin
        if (cpu_rst) begin
            chk("rst_cmd_rdy",   64'(bus.cpu_cmd_rdy), 64'(0));
            chk("rst_wr_valid",  64'(bus.cpu_wr_data_valid), 64'(0));
            chk("rst_mc_valid",  64'(bus.mc_cmd_valid), 64'(0));
            chk("rst_wd_empty",  64'(bus.mc_wr_data_empty), 64'(1));
            chk("rst_mc_fields", 64'({bus.mc_cmd, bus.mc_ba, bus.mc_addr}), 64'(0));
            chk("rst_mc_wdata",  bus.mc_wr_data, 64'(0));
            chk("rst_cmd_err",   64'(bus.cmd_err), 64'(0));
            chk("rst_stats",     64'({bus.stat_wr_cnt, bus.stat_rd_cnt}), 64'(0));
            m_cmdq.delete();
            m_dataq.delete();
            m_busy = 0; m_beats = 0; m_err = 0; m_wr = 0; m_rd = 0;
            acc_pending = 0;
        end else begin
            exp_rdy = !m_busy && (m_cmdq.size() < int'(DEPTH))
                      && (int'(DDEPTH) - m_dataq.size() >= int'(BL));
            chk("cpu_cmd_rdy",      64'(bus.cpu_cmd_rdy), 64'(exp_rdy));
            chk("cpu_wr_data_valid",64'(bus.cpu_wr_data_valid), 64'(m_busy));
            chk("mc_cmd_valid",     64'(bus.mc_cmd_valid), 64'(m_cmdq.size() != 0));
            chk("mc_wr_data_empty", 64'(bus.mc_wr_data_empty), 64'(m_dataq.size() == 0));
            chk("cmd_err",          64'(bus.cmd_err), 64'(m_err));
`ifdef DDR3_CMDQ_STATS_EN
            chk("stat_wr_cnt", 64'(bus.stat_wr_cnt), 64'(m_wr));
            chk("stat_rd_cnt", 64'(bus.stat_rd_cnt), 64'(m_rd));
`else
            chk("stat_tied0", 64'({bus.stat_wr_cnt, bus.stat_rd_cnt}), 64'(0));
`endif
            // Scoreboard pops on downstream handshakes
            if (bus.mc_cmd_valid && bus.mc_cmd_ready) begin
                if (m_cmdq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mc_cmd_unexpected: got %0h expected none at %0t",
                             {bus.mc_cmd, bus.mc_ba, bus.mc_addr}, $time);
                end else begin
                    exp_e = m_cmdq.pop_front();
                    chk("mc_cmd_head", 64'({bus.mc_cmd, bus.mc_ba, bus.mc_addr}), 64'(exp_e));
                end
            end
            if (!bus.mc_wr_data_empty && bus.mc_wr_data_pop) begin
                if (m_dataq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mc_wr_data_unexpected: got %0h expected none at %0t",
                             bus.mc_wr_data, $time);
                end else begin
                    exp_d = m_dataq.pop_front();
                    chk("mc_wr_data", bus.mc_wr_data, exp_d);
                end
            end
            // Effects of the coming edge
            acc_pending = 0;
            if (m_busy) begin
                m_dataq.push_back(bus.cpu_wr_data);
                m_beats++;
                if (m_beats == int'(BL)) begin
                    m_cmdq.push_back(m_pend);
                    m_busy = 0;
                    m_wr = sat16(m_wr);
                end
            end else if (bus.cpu_addr_valid && exp_rdy) begin
                acc_pending = 1;
                if (bus.cpu_cmd == CMD_READ) begin
                    m_cmdq.push_back('{cmd: bus.cpu_cmd, ba: bus.cpu_ba, addr: bus.cpu_addr});
                    m_rd = sat16(m_rd);
                end else if (bus.cpu_cmd == CMD_WRITE) begin
                    m_pend  = '{cmd: bus.cpu_cmd, ba: bus.cpu_ba, addr: bus.cpu_addr};
                    m_busy  = 1;
                    m_beats = 0;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    // Present a request and hold it until the model reports it accepted.
    task automatic issue(input logic [2:0] c, input logic [2:0] ba, input logic [14:0] a);
        bus.cpu_addr_valid = 1'b1;
        bus.cpu_cmd        = c;
        bus.cpu_ba         = ba;
        bus.cpu_addr       = a;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            ok = acc_pending;
        end
        bus.cpu_addr_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL issue_timeout: got no accept expected accept of cmd %0h at %0t", c, $time);
        end
    endtask

    task automatic write_burst(input logic [2:0] ba, input logic [14:0] a, input logic [63:0] base);
        issue(CMD_WRITE, ba, a);
        for (int i = 0; i < int'(BL); i++) begin
            bus.cpu_wr_data = base + 64'(i);
            tick();
        end
    endtask

    task automatic pulse_reset();
        cpu_rst = 1'b1;
        tick();
        cpu_rst = 1'b0;
    endtask

    initial begin
        bus.cpu_addr_valid = 1'b0;
        bus.cpu_cmd        = '0;
        bus.cpu_ba         = '0;
        bus.cpu_addr       = '0;
        bus.cpu_wr_data    = '0;
        bus.mc_cmd_ready   = 1'b0;
        bus.mc_wr_data_pop = 1'b0;
        repeat (3) tick();
        cpu_rst = 1'b0;
        tick();

        // Single READ, drained immediately
        bus.mc_cmd_ready = 1'b1;
        issue(CMD_READ, 3'd2, 15'h7FFD);
        repeat (3) tick();

        // WRITE with beats 0..7, then drain data
        write_burst(3'd0, 15'h7FFD, 64'd0);
        repeat (2) tick();
        bus.mc_wr_data_pop = 1'b1;
        repeat (BL + 3) tick();
        bus.mc_wr_data_pop = 1'b0;

        // Fill the command FIFO, then release it together with a 5th request
        bus.mc_cmd_ready = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) issue(CMD_READ, 3'(i), 15'($urandom));
        repeat (2) tick();
        bus.mc_cmd_ready = 1'b1;
        issue(CMD_READ, 3'd5, 15'h1234);
        repeat (6) tick();

        // Reset in the middle of a burst
        issue(CMD_WRITE, 3'd1, 15'h0042);
        for (int i = 0; i < 4; i++) begin
            bus.cpu_wr_data = 64'hA0 + 64'(i);
            tick();
        end
        pulse_reset();
        bus.mc_wr_data_pop = 1'b1;
        repeat (4) tick();

        // Invalid command, then 3 WRITEs and 2 READs
        issue(3'b111, 3'd3, 15'h0001);
        tick();
        chk("cmd_err_set", 64'(bus.cmd_err), 64'(1));
        write_burst(3'd1, 15'h0100, 64'h1000);
        issue(CMD_READ, 3'd2, 15'h0200);
        write_burst(3'd3, 15'h0300, 64'h2000);
        issue(CMD_READ, 3'd4, 15'h0400);
        write_burst(3'd5, 15'h0500, 64'h3000);
        repeat (30) tick();
        chk("cmd_err_sticky", 64'(bus.cmd_err), 64'(1));
`ifdef DDR3_CMDQ_STATS_EN
        chk("stat_wr_final", 64'(bus.stat_wr_cnt), 64'(3));
        chk("stat_rd_final", 64'(bus.stat_rd_cnt), 64'(2));
`else
        chk("stat_off_final", 64'({bus.stat_wr_cnt, bus.stat_rd_cnt}), 64'(0));
`endif
        pulse_reset();
        tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 15));
            bus.cpu_addr_valid = 1'($urandom_range(0, 1));
            bus.cpu_cmd        = (r < 7) ? CMD_READ : (r < 14) ? CMD_WRITE : 3'($urandom);
            bus.cpu_ba         = 3'($urandom);
            bus.cpu_addr       = 15'($urandom);
            bus.cpu_wr_data    = {32'($urandom), 32'($urandom)};
            bus.mc_cmd_ready   = ($urandom_range(0, 3) != 0);
            bus.mc_wr_data_pop = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 399) == 0) pulse_reset();
            else tick();
        end
        bus.cpu_addr_valid = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
